// File: rtl/ecliptic_int_to_float.sv
// Multi-cycle integer to IEEE-754 binary32 converter (FCVT.S.W / FCVT.S.WU).
// Iterative byte-wise normalization followed by a single rounding cycle; req/ack handshake.
module ecliptic_int_to_float #(
   parameter int NORM_STEPS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] src,
   input  logic        is_unsigned,
   input  logic [2:0]  rm,
   input  logic        req,
   output logic        busy,
   output logic [31:0] res,
   output logic [4:0]  fflags,
   output logic        ack
);

   localparam int CW = $clog2(NORM_STEPS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rm_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic            r_sign;
   logic [31:0]     r_mant;
   logic [7:0]      r_exp;
   logic [2:0]      r_rm;

   logic            w_neg;
   logic [31:0]     w_mag;
   logic [3:0]      w_lz;
   logic [31:0]     w_mant_norm;
   logic [7:0]      w_exp_norm;
   logic            w_g;
   logic            w_s;
   logic            w_nx;
   logic            w_inc;
   logic [30:0]     w_mag_rnd;
   logic [31:0]     w_res;
   logic [4:0]      w_fflags;

   function automatic logic [2:0] lz8(input logic [7:0] b);
      casez (b)
         8'b1???????: lz8 = 3'd0;
         8'b01??????: lz8 = 3'd1;
         8'b001?????: lz8 = 3'd2;
         8'b0001????: lz8 = 3'd3;
         8'b00001???: lz8 = 3'd4;
         8'b000001??: lz8 = 3'd5;
         8'b0000001?: lz8 = 3'd6;
         default:     lz8 = 3'd7;
      endcase
   endfunction

   assign w_neg = ~is_unsigned & src[31];
   assign w_mag = w_neg ? (~src + 32'd1) : src;

   // A zero top byte takes a full 8-bit step; otherwise shift out its leading zeros.
   assign w_lz        = (r_mant[31:24] == 8'd0) ? 4'd8 : {1'b0, lz8(r_mant[31:24])};
   assign w_mant_norm = r_mant << w_lz;
   assign w_exp_norm  = r_exp - {4'd0, w_lz};

   assign w_g  = r_mant[7];
   assign w_s  = |r_mant[6:0];
   assign w_nx = w_g | w_s;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      w_inc = 1'b0;
      case (rm_t'(r_rm))
         RM_RNE:  w_inc = w_g & (w_s | r_mant[8]);
         RM_RTZ:  w_inc = 1'b0;
         RM_RDN:  w_inc = r_sign & w_nx;
         RM_RUP:  w_inc = ~r_sign & w_nx;
         RM_RMM:  w_inc = w_g;
         default: w_inc = 1'b0;
      endcase
   end

   // Incrementing {exp, frac} as one field lets a mantissa carry bump the exponent.
   assign w_mag_rnd = {r_exp, r_mant[30:8]} + {30'd0, w_inc};

   always_comb begin
      w_res    = {r_sign, w_mag_rnd};
      w_fflags = {4'b0000, w_nx};
      if (r_rm > 3'd4) begin
         w_res    = 32'h7FC0_0000;
         w_fflags = 5'b10000;
      end else if (r_mant == 32'd0) begin
         w_res    = 32'h0000_0000;
         w_fflags = 5'b00000;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = (r_state != S_IDLE);
      ack         = (r_state == S_DONE);
      case (r_state)
         S_IDLE:  if (req) w_state_nxt = S_NORM;
         S_NORM:  if (r_cnt == CW'(NORM_STEPS - 1)) w_state_nxt = S_ROUND;
         S_ROUND: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         res     <= 32'd0;
         fflags  <= 5'd0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && req) r_cnt <= '0;
         if (r_state == S_NORM)        r_cnt <= r_cnt + CW'(1);
         if (r_state == S_ROUND) begin
            res    <= w_res;
            fflags <= w_fflags;
         end
      end
   end

   // NOTE: the operand datapath is fully loaded on accept, so it carries no reset.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && req) begin
         r_sign <= w_neg;
         r_mant <= w_mag;
         r_exp  <= 8'd158;
         r_rm   <= rm;
      end else if (r_state == S_NORM) begin
         r_mant <= w_mant_norm;
         r_exp  <= w_exp_norm;
      end
   end

endmodule

// File: tb/tb_ecliptic_int_to_float.sv
// Scoreboard bench for ecliptic_int_to_float: directed vectors pushed on issue,
// popped and compared by an independent monitor on each ack.
module tb_ecliptic_int_to_float;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] src;
   logic        is_unsigned;
   logic [2:0]  rm;
   logic        req;
   logic        busy;
   logic [31:0] res;
   logic [4:0]  fflags;
   logic        ack;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  ff;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic prev_ack = 1'b0;

   ecliptic_int_to_float #(.NORM_STEPS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .src         (src),
      .is_unsigned (is_unsigned),
      .rm          (rm),
      .req         (req),
      .busy        (busy),
      .res         (res),
      .fflags      (fflags),
      .ack         (ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per ack, checks result, flags, latency and pulse width.
   always @(negedge clk) begin
      if (!rst && ack) begin
         check("ack_width", {31'd0, prev_ack}, 32'd0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack actual=res %h expected=no ack", res);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("res", res, e.res);
            check("fflags", {27'd0, fflags}, {27'd0, e.ff});
            check("latency", 32'(cyc - e.acc), 32'd5);
         end
      end
      prev_ack = ack;
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=busy expected=idle");
      end
   endtask

   task automatic do_op(input logic [31:0] s, input logic u, input logic [2:0] r,
                        input logic [31:0] e_res, input logic [4:0] e_ff);
      exp_t e;
      wait_idle();
      src = s; is_unsigned = u; rm = r; req = 1'b1;
      e.res = e_res; e.ff = e_ff; e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      req = 1'b0;
      src = 32'hDEAD_BEEF; is_unsigned = 1'bx; rm = 3'bx;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; src = 32'd0; is_unsigned = 1'b0; rm = 3'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_res", res, 32'd0);
      check("rst_fflags", {27'd0, fflags}, 32'd0);

      do_op(32'h0000_0001, 1'b0, 3'd0, 32'h3F80_0000, 5'h00);
      do_op(32'hFFFF_FFFF, 1'b0, 3'd0, 32'hBF80_0000, 5'h00);
      do_op(32'h7FFF_FFFF, 1'b0, 3'd0, 32'h4F00_0000, 5'h01);
      do_op(32'h7FFF_FFFF, 1'b0, 3'd1, 32'h4EFF_FFFF, 5'h01);
      do_op(32'hFFFF_FFFF, 1'b1, 3'd0, 32'h4F80_0000, 5'h01);
      do_op(32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 5'h01);
      do_op(32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 5'h01);
      do_op(32'h0100_0001, 1'b0, 3'd4, 32'h4B80_0001, 5'h01);
      do_op(32'h0100_0003, 1'b0, 3'd0, 32'h4B80_0002, 5'h01);
      do_op(32'hFEFF_FFFF, 1'b0, 3'd2, 32'hCB80_0001, 5'h01);
      do_op(32'hFEFF_FFFF, 1'b0, 3'd3, 32'hCB80_0000, 5'h01);
      do_op(32'h8000_0000, 1'b0, 3'd0, 32'hCF00_0000, 5'h00);
      do_op(32'h8000_0000, 1'b1, 3'd0, 32'h4F00_0000, 5'h00);
      do_op(32'h0000_0000, 1'b0, 3'd2, 32'h0000_0000, 5'h00);
      do_op(32'h1234_5678, 1'b0, 3'd6, 32'h7FC0_0000, 5'h10);
      wait_drain();
      check("res_held", res, 32'h7FC0_0000);

      // Requests during busy cycles 2-5 must be ignored.
      do_op(32'h0000_0100, 1'b0, 3'd0, 32'h4380_0000, 5'h00);
      @(posedge clk); #1;
      req = 1'b1; src = 32'hFFFF_FFFF; is_unsigned = 1'b0; rm = 3'd1;
      repeat (4) begin @(posedge clk); #1; end
      req = 1'b0;
      wait_drain();
      repeat (10) @(posedge clk);

      // Reset mid-NORM aborts the operation without an ack.
      #1;
      src = 32'h0000_0007; is_unsigned = 1'b0; rm = 3'd0; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      check("norm_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_ack", {31'd0, ack}, 32'd0);
      check("abort_res", res, 32'd0);
      repeat (10) @(posedge clk);
      #1;
      do_op(32'h0000_0005, 1'b0, 3'd0, 32'h40A0_0000, 5'h00);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
